// File: rtl/pwm_ramp_ctrl.sv
// APB master that programs one pwm channel and ramps its duty register in fixed steps.
// Optional PWM_RAMP_LOOP_EN: swap start/end on arrival and keep ramping (triangle wave).
module pwm_ramp_ctrl #(
  parameter int unsigned NUM_CHANNELS = 2,
  parameter logic [31:0] BASE_ADDR    = 32'h0,
  parameter logic [2:0]  CTRL_ON      = 3'b001,
  localparam int         CH_W         = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            stop,
  input  logic [CH_W-1:0] ch,
  input  logic [31:0]     period,
  input  logic [31:0]     duty_start,
  input  logic [31:0]     duty_end,
  input  logic [31:0]     step,
  input  logic [15:0]     hold_cycles,
  output logic            busy,
  output logic            done,
  output logic [31:0]     paddr,
  output logic [31:0]     pwdata,
  output logic            psel,
  output logic            penable,
  output logic            pwrite
);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_ACCESS, S_HOLD, S_OFF_SETUP, S_OFF_ACCESS
  } state_t;

  typedef enum logic [1:0] {W_PERIOD, W_DUTY, W_CTRL, W_RAMP} wsel_t;

  localparam logic [1:0] IDX_PERIOD = 2'd0;
  localparam logic [1:0] IDX_DUTY   = 2'd1;
  localparam logic [1:0] IDX_CTRL   = 2'd2;

  state_t          state;
  wsel_t           wsel;
  logic [CH_W-1:0] ch_q;
  logic [31:0]     dend_q;
  logic [31:0]     step_q;
  logic [15:0]     hold_q;
  logic [15:0]     hold_cnt;
  logic [31:0]     duty_cur;
  logic            stop_pend;
`ifdef PWM_RAMP_LOOP_EN
  logic [31:0]     dstart_q;
`endif

  logic [31:0] diff;
  logic [31:0] duty_next;
  logic        up;
  logic [15:0] hold_load;

  function automatic logic [31:0] reg_addr(input logic [CH_W-1:0] c, input logic [1:0] idx);
    return BASE_ADDR + 32'(4 * (3 * int'(c) + int'(idx)));
  endfunction

  // Step toward duty_end without ever passing it; step==0 means jump straight there.
  always_comb begin
    up        = dend_q > duty_cur;
    diff      = up ? (dend_q - duty_cur) : (duty_cur - dend_q);
    hold_load = (hold_q == 16'd0) ? 16'd1 : hold_q;
    if (step_q == 32'd0 || step_q >= diff) duty_next = dend_q;
    else if (up)                           duty_next = duty_cur + step_q;
    else                                   duty_next = duty_cur - step_q;
  end

  // NOTE: all sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, regardless of statement order in this block.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      wsel      <= W_PERIOD;
      ch_q      <= '0;
      dend_q    <= '0;
      step_q    <= '0;
      hold_q    <= '0;
      hold_cnt  <= '0;
      duty_cur  <= '0;
      stop_pend <= 1'b0;
`ifdef PWM_RAMP_LOOP_EN
      dstart_q  <= '0;
`endif
      busy      <= 1'b0;
      done      <= 1'b0;
      paddr     <= '0;
      pwdata    <= '0;
      psel      <= 1'b0;
      penable   <= 1'b0;
      pwrite    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          stop_pend <= 1'b0;
          if (start && !stop && (32'(ch) < NUM_CHANNELS)) begin
            ch_q     <= ch;
            dend_q   <= duty_end;
            step_q   <= step;
            hold_q   <= hold_cycles;
            duty_cur <= duty_start;
`ifdef PWM_RAMP_LOOP_EN
            dstart_q <= duty_start;
`endif
            wsel     <= W_PERIOD;
            state    <= S_SETUP;
            busy     <= 1'b1;
            psel     <= 1'b1;
            pwrite   <= 1'b1;
            paddr    <= reg_addr(ch, IDX_PERIOD);
            pwdata   <= period;
          end
        end
        S_SETUP: begin
          penable <= 1'b1;
          state   <= S_ACCESS;
          if (stop) stop_pend <= 1'b1;
        end
        S_ACCESS: begin
          penable <= 1'b0;
          if (stop || stop_pend) begin
            stop_pend <= 1'b0;
            state     <= S_OFF_SETUP;
            paddr     <= reg_addr(ch_q, IDX_CTRL);
            pwdata    <= '0;
          end else if (wsel == W_PERIOD) begin
            wsel   <= W_DUTY;
            state  <= S_SETUP;
            paddr  <= reg_addr(ch_q, IDX_DUTY);
            pwdata <= duty_cur;
          end else if (wsel == W_DUTY) begin
            wsel   <= W_CTRL;
            state  <= S_SETUP;
            paddr  <= reg_addr(ch_q, IDX_CTRL);
            pwdata <= 32'(CTRL_ON);
          end else if (duty_cur != dend_q) begin
            state    <= S_HOLD;
            psel     <= 1'b0;
            pwrite   <= 1'b0;
            hold_cnt <= hold_load;
          end else begin
`ifdef PWM_RAMP_LOOP_EN
            dend_q   <= dstart_q;
            dstart_q <= dend_q;
            state    <= S_HOLD;
            psel     <= 1'b0;
            pwrite   <= 1'b0;
            hold_cnt <= hold_load;
`else
            state  <= S_IDLE;
            busy   <= 1'b0;
            done   <= 1'b1;
            psel   <= 1'b0;
            pwrite <= 1'b0;
`endif
          end
        end
        S_HOLD: begin
          if (stop) begin
            state  <= S_OFF_SETUP;
            psel   <= 1'b1;
            pwrite <= 1'b1;
            paddr  <= reg_addr(ch_q, IDX_CTRL);
            pwdata <= '0;
          end else if (hold_cnt <= 16'd1) begin
            state    <= S_SETUP;
            wsel     <= W_RAMP;
            duty_cur <= duty_next;
            psel     <= 1'b1;
            pwrite   <= 1'b1;
            paddr    <= reg_addr(ch_q, IDX_DUTY);
            pwdata   <= duty_next;
          end else begin
            hold_cnt <= hold_cnt - 16'd1;
          end
        end
        S_OFF_SETUP: begin
          penable <= 1'b1;
          state   <= S_OFF_ACCESS;
        end
        S_OFF_ACCESS: begin
          psel    <= 1'b0;
          penable <= 1'b0;
          pwrite  <= 1'b0;
          busy    <= 1'b0;
          state   <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Directed bench for pwm_ramp_ctrl; NUM_CHANNELS=3 so an out-of-range ch (3) is encodable.
// Define PWM_RAMP_LOOP_EN for both files to run the triangle-wave sequence instead.
module tb_pwm_ramp_ctrl;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    int          cyc;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [1:0]  ch = '0;
  logic [31:0] period = '0;
  logic [31:0] duty_start = '0;
  logic [31:0] duty_end = '0;
  logic [31:0] step = '0;
  logic [15:0] hold_cycles = '0;
  logic        busy, done, psel, penable, pwrite;
  logic [31:0] paddr, pwdata;

  int  n_checks = 0;
  int  n_fail = 0;
  int  cyc = 0;
  int  done_cnt = 0;
  int  done_cyc = 0;
  wr_t wlog[$];
  wr_t mon_w;

  pwm_ramp_ctrl #(.NUM_CHANNELS(3), .BASE_ADDR(32'h8000), .CTRL_ON(3'b001)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .ch(ch), .period(period),
    .duty_start(duty_start), .duty_end(duty_end), .step(step), .hold_cycles(hold_cycles),
    .busy(busy), .done(done), .paddr(paddr), .pwdata(pwdata), .psel(psel),
    .penable(penable), .pwrite(pwrite)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Record every completed APB write and each done pulse, sampled mid-cycle.
  always @(negedge clk) begin
    if (psel && penable && pwrite) begin
      mon_w.addr = paddr;
      mon_w.data = pwdata;
      mon_w.cyc  = cyc;
      wlog.push_back(mon_w);
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_write(input int idx, input logic [31:0] addr, input logic [31:0] data,
                              input string tag);
    if (idx < wlog.size()) begin
      check({tag, ".addr"}, wlog[idx].addr, addr);
      check({tag, ".data"}, wlog[idx].data, data);
    end else begin
      check({tag, ".present"}, 32'(wlog.size()), 32'(idx + 1));
    end
  endtask

  task automatic launch(input logic [1:0] c, input logic [31:0] p, input logic [31:0] ds,
                        input logic [31:0] de, input logic [31:0] s, input logic [15:0] h);
    ch = c; period = p; duty_start = ds; duty_end = de; step = s; hold_cycles = h;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Run until busy falls; checks done coincides with that cycle, then lets the monitor see it.
  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy === 1'b1 && n < 500) begin
      tick();
      n++;
    end
    check({tag, ".finished"}, 32'(n < 500), 32'd1);
    check({tag, ".done_with_idle"}, 32'(done), 32'd1);
    tick();
  endtask

  task automatic wait_writes(input int count, input string tag);
    int n = 0;
    while (wlog.size() < count && n < 500) begin
      tick();
      n++;
    end
    check({tag, ".reached"}, 32'(n < 500), 32'd1);
  endtask

  int base, dbase;

  initial begin
    // Reset held three cycles, then a quiet bus for ten.
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    tick();
    check("rst.psel", 32'(psel), 0);
    check("rst.penable", 32'(penable), 0);
    check("rst.pwrite", 32'(pwrite), 0);
    check("rst.paddr", paddr, 0);
    check("rst.pwdata", pwdata, 0);
    check("rst.busy", 32'(busy), 0);
    check("rst.done", 32'(done), 0);
    tick(10);
    check("rst.quiet", 32'(wlog.size()), 0);

`ifdef PWM_RAMP_LOOP_EN
    launch(2'd0, 32'd64, 32'd0, 32'd20, 32'd10, 16'd1);
    wait_writes(8, "loop");
    expect_write(0, 32'h8000, 64, "loop.w0");
    expect_write(1, 32'h8004, 0, "loop.w1");
    expect_write(2, 32'h8008, 1, "loop.w2");
    expect_write(3, 32'h8004, 10, "loop.w3");
    expect_write(4, 32'h8004, 20, "loop.w4");
    expect_write(5, 32'h8004, 10, "loop.w5");
    expect_write(6, 32'h8004, 0, "loop.w6");
    expect_write(7, 32'h8004, 10, "loop.w7");
    check("loop.busy", 32'(busy), 1);
    while (dut.state != dut.S_HOLD) tick();
    base = wlog.size();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    tick(3);
    check("loop.stop_writes", 32'(wlog.size() - base), 1);
    expect_write(base, 32'h8008, 0, "loop.off");
    check("loop.stop_busy", 32'(busy), 0);
    check("loop.no_done", 32'(done_cnt), 0);
`else
    // Basic up-ramp on channel 1 with first-transfer timing.
    launch(2'd1, 32'd100, 32'd10, 32'd40, 32'd10, 16'd5);
    check("a.busy_k1", 32'(busy), 1);
    check("a.psel_k1", 32'(psel), 1);
    check("a.penable_k1", 32'(penable), 0);
    check("a.pwrite_k1", 32'(pwrite), 1);
    check("a.paddr_k1", paddr, 32'h800C);
    check("a.pwdata_k1", pwdata, 100);
    tick();
    check("a.penable_k2", 32'(penable), 1);
    check("a.paddr_k2", paddr, 32'h800C);
    tick();
    check("a.psel_b2b", 32'(psel), 1);
    check("a.penable_b2b", 32'(penable), 0);
    wait_idle("a");
    check("a.count", 32'(wlog.size()), 6);
    expect_write(0, 32'h800C, 100, "a.w0");
    expect_write(1, 32'h8010, 10, "a.w1");
    expect_write(2, 32'h8014, 1, "a.w2");
    expect_write(3, 32'h8010, 20, "a.w3");
    expect_write(4, 32'h8010, 30, "a.w4");
    expect_write(5, 32'h8010, 40, "a.w5");
    if (wlog.size() == 6) begin
      check("a.gap1", 32'(wlog[3].cyc - wlog[2].cyc), 7);
      check("a.gap3", 32'(wlog[5].cyc - wlog[4].cyc), 7);
      check("a.done_lat", 32'(done_cyc - wlog[5].cyc), 1);
    end
    check("a.done_cnt", 32'(done_cnt), 1);
    check("a.idle_psel", 32'(psel), 0);
    check("a.idle_pwrite", 32'(pwrite), 0);

    // Down-ramp with the last step clamped at duty_end.
    base = wlog.size();
    launch(2'd0, 32'd200, 32'd50, 32'd5, 32'd20, 16'd2);
    wait_idle("b");
    check("b.count", 32'(wlog.size() - base), 6);
    expect_write(base + 0, 32'h8000, 200, "b.w0");
    expect_write(base + 1, 32'h8004, 50, "b.w1");
    expect_write(base + 2, 32'h8008, 1, "b.w2");
    expect_write(base + 3, 32'h8004, 30, "b.w3");
    expect_write(base + 4, 32'h8004, 10, "b.w4");
    expect_write(base + 5, 32'h8004, 5, "b.w5");
    check("b.done_cnt", 32'(done_cnt), 2);

    // Stop during HOLD after the DUTY=20 write.
    base = wlog.size();
    launch(2'd1, 32'd100, 32'd10, 32'd40, 32'd10, 16'd5);
    wait_writes(base + 4, "c");
    expect_write(base + 3, 32'h8010, 20, "c.w3");
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("c.off_psel", 32'(psel), 1);
    check("c.off_penable", 32'(penable), 0);
    check("c.off_paddr", paddr, 32'h8014);
    check("c.off_pwdata", pwdata, 0);
    tick();
    check("c.off_access", 32'(penable), 1);
    tick();
    check("c.busy", 32'(busy), 0);
    check("c.psel", 32'(psel), 0);
    tick(10);
    check("c.count", 32'(wlog.size() - base), 5);
    expect_write(base + 4, 32'h8014, 0, "c.off");
    check("c.no_done", 32'(done_cnt), 2);

    // start and stop together while idle.
    base = wlog.size();
    stop = 1'b1;
    launch(2'd0, 32'd1, 32'd1, 32'd2, 32'd1, 16'd1);
    stop = 1'b0;
    check("d.busy", 32'(busy), 0);
    tick(10);
    check("d.quiet", 32'(wlog.size() - base), 0);

    // duty_start == duty_end: only the three setup writes.
    base = wlog.size();
    launch(2'd0, 32'd9, 32'd7, 32'd7, 32'd3, 16'd4);
    wait_idle("e");
    check("e.count", 32'(wlog.size() - base), 3);
    expect_write(base + 1, 32'h8004, 7, "e.w1");
    expect_write(base + 2, 32'h8008, 1, "e.w2");
    check("e.done_cnt", 32'(done_cnt), 3);

    // step == 0 jumps straight to the end value; channel 2.
    base = wlog.size();
    launch(2'd2, 32'd50, 32'd0, 32'd33, 32'd0, 16'd3);
    wait_idle("f");
    check("f.count", 32'(wlog.size() - base), 4);
    expect_write(base + 0, 32'h8018, 50, "f.w0");
    expect_write(base + 2, 32'h8020, 1, "f.w2");
    expect_write(base + 3, 32'h801C, 33, "f.w3");

    // hold_cycles == 0 behaves as a single hold clock.
    base = wlog.size();
    launch(2'd1, 32'd10, 32'd1, 32'd3, 32'd1, 16'd0);
    wait_idle("g");
    check("g.count", 32'(wlog.size() - base), 5);
    expect_write(base + 3, 32'h8010, 2, "g.w3");
    expect_write(base + 4, 32'h8010, 3, "g.w4");
    if (wlog.size() - base == 5)
      check("g.gap", 32'(wlog[base + 4].cyc - wlog[base + 3].cyc), 3);

    // Out-of-range channel is ignored.
    base = wlog.size();
    dbase = done_cnt;
    launch(2'd3, 32'd10, 32'd1, 32'd3, 32'd1, 16'd1);
    check("h.busy", 32'(busy), 0);
    tick(10);
    check("h.quiet", 32'(wlog.size() - base), 0);
    check("h.no_done", 32'(done_cnt - dbase), 0);

    // Reset in the middle of a transfer: no CONTROL=0 write follows.
    base = wlog.size();
    launch(2'd0, 32'd10, 32'd1, 32'd3, 32'd1, 16'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("r.psel", 32'(psel), 0);
    check("r.paddr", paddr, 0);
    check("r.busy", 32'(busy), 0);
    tick(5);
    check("r.quiet", 32'(wlog.size() - base), 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
